odo_sbox_lanes: RTL and testbench

//  Runtime-loadable, multi-lane W-bit substitution box for the Odo round datapath.

---
 rtl/odo_sbox_pkg.sv | 27 ++
 rtl/odo_sbox_ram.sv | 43 ++++
 rtl/odo_sbox_lanes.sv | 201 ++++++++++++++++++++
 tb/tb_odo_sbox_lanes.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odo_sbox_pkg.sv
// Shared types and defaults for the Odo runtime-loadable substitution box.
//   SBOX_W     : default sbox width in bits (table depth is 2**SBOX_W)
//   SBOX_LANES : default number of parallel lookup lanes per beat
//   state_e    : load/run controller states
//   lane()     : extract lane i from a packed multi-lane vector
// Optional feature macro used by this slice: ODO_SBOX_INV_EN (inverse lookup).
package odo_sbox_pkg;

  localparam int unsigned SBOX_W     = 6;
  localparam int unsigned SBOX_LANES = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Lane i sits at bits [i*SBOX_W +: SBOX_W].
  function automatic logic [SBOX_W-1:0] lane(
    input logic [SBOX_LANES*SBOX_W-1:0] vec,
    input int unsigned                  i
  );
    return vec[i*SBOX_W +: SBOX_W];
  endfunction

endpackage

// File: rtl/odo_sbox_ram.sv
// Table storage for the sbox: 2**W entries of W bits, one synchronous write
// port and N_RD synchronous read ports. Contents are not reset.
//   clk   : clock
//   we    : write enable; mem[waddr] <= wdata
//   waddr : write address
//   wdata : write data
//   re    : read enable; when low the read registers hold their value
//   raddr : N_RD packed read addresses, port i at [i*W +: W]
//   rdata : N_RD packed registered read results
module odo_sbox_ram #(
  parameter int unsigned W    = 6,
  parameter int unsigned N_RD = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [W-1:0]      waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [N_RD*W-1:0] raddr,
  output logic [N_RD*W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << W;

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports; holding on !re lets the caller freeze the pipeline.
  always_ff @(posedge clk) begin
    if (re) begin
      for (int unsigned i = 0; i < N_RD; i++) begin
        rdata[i*W +: W] <= mem[raddr[i*W +: W]];
      end
    end
  end

endmodule

// File: rtl/odo_sbox_lanes.sv
// Runtime-loadable multi-lane W-bit substitution box. The table is streamed in
// address order, checked to be a permutation, then used for N_LANES parallel
// lookups per beat through a stallable 2-stage pipeline.
// Optional macro ODO_SBOX_INV_EN adds in_inv and an inverse table.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ld_start            : begin a new table load
//   ld_valid/ld_ready   : load beat handshake, ld_data is the next entry
//   tbl_ok              : table loaded and is a permutation
//   perm_err            : sticky duplicate-entry flag for the current load
//   in_valid/in_ready   : lookup beat handshake, in_data holds N_LANES lanes
//   in_inv              : (ODO_SBOX_INV_EN only) return inverse lookups
//   out_valid/out_ready : result handshake, out_data holds N_LANES results
module odo_sbox_lanes
  import odo_sbox_pkg::*;
#(
  parameter int unsigned W       = SBOX_W,
  parameter int unsigned N_LANES = SBOX_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [W-1:0]         ld_data,
  output logic                 ld_ready,
  output logic                 tbl_ok,
  output logic                 perm_err,
  input  logic                 in_valid,
`ifdef ODO_SBOX_INV_EN
  input  logic                 in_inv,
`endif
  output logic                 in_ready,
  input  logic [N_LANES*W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_LANES*W-1:0] out_data
);

  localparam int unsigned DW    = N_LANES * W;
  localparam int unsigned DEPTH = 32'd1 << W;
  localparam int unsigned AW    = W + 1;

  state_e         state;
  state_e         state_nxt;
  logic [AW-1:0]  addr;
  logic [DEPTH-1:0] seen;
  logic           s1_valid;
  logic           stall;
  logic           rd_en;
  logic           accept;
  logic           ld_beat;
  logic           last_beat;
  logic           dup;
  logic           pipe_empty;
  logic [DW-1:0]  rd_fwd;
  logic [DW-1:0]  rd_sel;

  assign stall      = out_valid && !out_ready;
  assign rd_en      = !stall;
  assign pipe_empty = !s1_valid && !out_valid;
  // A restart request discards any beat presented in the same cycle.
  assign ld_beat    = (state == LOAD) && ld_valid && !ld_start;
  // Counter is one bit wider than the table address so the last beat never wraps.
  assign last_beat  = ld_beat && (addr == AW'(DEPTH - 1));
  assign dup        = seen[ld_data];
  assign accept     = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (ld_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ld_start)        state_nxt = DRAIN;
        else if (pipe_empty) state_nxt = LOAD;
      end
      LOAD: begin
        if (ld_start) begin
          state_nxt = DRAIN;
        end else if (last_beat) begin
          state_nxt = (perm_err || dup) ? EMPTY : RUN;
        end
      end
      RUN: begin
        if (ld_start) state_nxt = DRAIN;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Outputs decoded from state; ld_start blocks input in the same cycle.
  always_comb begin
    ld_ready = 1'b0;
    tbl_ok   = 1'b0;
    in_ready = 1'b0;
    case (state)
      LOAD: ld_ready = 1'b1;
      RUN: begin
        tbl_ok   = 1'b1;
        in_ready = !stall && !ld_start;
      end
      default: begin
        ld_ready = 1'b0;
      end
    endcase
  end

  // Load address, seen-bitmap and duplicate tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      seen     <= '0;
      perm_err <= 1'b0;
    end else if (ld_start) begin
      addr <= '0;
      seen <= '0;
    end else if (state == DRAIN && state_nxt == LOAD) begin
      addr     <= '0;
      seen     <= '0;
      perm_err <= 1'b0;
    end else if (ld_beat) begin
      addr          <= addr + AW'(1);
      seen[ld_data] <= 1'b1;
      if (dup) begin
        perm_err <= 1'b1;
      end
    end
  end

  // Forward table: T[addr] = ld_data; reads issued with the S1 capture.
  odo_sbox_ram #(
    .W    (W),
    .N_RD (N_LANES)
  ) u_ram_fwd (
    .clk   (clk),
    .we    (ld_beat),
    .waddr (addr[W-1:0]),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (in_data),
    .rdata (rd_fwd)
  );

`ifdef ODO_SBOX_INV_EN
  logic          s1_inv;
  logic [DW-1:0] rd_inv;

  // Inverse table: Tinv[ld_data] = addr.
  odo_sbox_ram #(
    .W    (W),
    .N_RD (N_LANES)
  ) u_ram_inv (
    .clk   (clk),
    .we    (ld_beat),
    .waddr (ld_data),
    .wdata (addr[W-1:0]),
    .re    (rd_en),
    .raddr (in_data),
    .rdata (rd_inv)
  );

  // Direction flag travels alongside the S1 read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inv <= 1'b0;
    end else if (!stall) begin
      s1_inv <= in_inv;
    end
  end

  assign rd_sel = s1_inv ? rd_inv : rd_fwd;
`else
  assign rd_sel = rd_fwd;
`endif

  // S1 valid and S2 output register; a stall freezes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_odo_sbox_lanes.sv
// Self-checking bench for odo_sbox_lanes: table-driven lookup vectors plus
// directed sequences for load, stall, reload-while-busy, bad-table and reset.
module tb_odo_sbox_lanes;
  import odo_sbox_pkg::*;

  localparam int unsigned W  = SBOX_W;
  localparam int unsigned NL = SBOX_LANES;
  localparam int unsigned DW = W * NL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start;
  logic          ld_valid;
  logic [W-1:0]  ld_data;
  logic          ld_ready;
  logic          tbl_ok;
  logic          perm_err;
  logic          in_valid;
  logic          in_inv;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  odo_sbox_lanes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .tbl_ok    (tbl_ok),
    .perm_err  (perm_err),
    .in_valid  (in_valid),
`ifdef ODO_SBOX_INV_EN
    .in_inv    (in_inv),
`endif
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  bit            lat_chk = 1'b0;
  logic [DW-1:0] cur_exp;
  logic [DW-1:0] exp_q [$];
  int            stamp_q [$];

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Test permutation P[a] = 37*a + 11 mod 64 (37 is odd, so bijective).
  function automatic logic [W-1:0] p(input logic [W-1:0] a);
    return a * W'(37) + W'(11);
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NL; i++) r[i*W +: W] = p(lane(d, i));
    return r;
  endfunction

  // kind 0: P, kind 1: identity with 0x05 repeated at addr 10, kind 2: reversed.
  function automatic logic [W-1:0] val(input int kind, input int a);
    if (kind == 0) return p(W'(a));
    if (kind == 1) return (a == 10) ? W'(5) : W'(a);
    return W'(63 - a);
  endfunction

  always @(posedge clk) cyc++;

  // Output scoreboard: expected results are pushed at acceptance.
  always begin
    logic [DW-1:0] e;
    int            s;
    @(negedge clk);
    #1;
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_data), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          s = stamp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
          if (lat_chk) check("latency", 32'(cyc - s), 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        stamp_q.push_back(cyc);
      end
    end
  end

  task automatic start_load();
    int k;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    check("tbl_ok_fall", 32'(tbl_ok), 32'd0);
    k = 0;
    while (!ld_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ld_ready_up", 32'(ld_ready), 32'd1);
  endtask

  task automatic feed(input int kind, input int n);
    for (int a = 0; a < n; a++) begin
      ld_valid = 1'b1;
      ld_data  = val(kind, a);
      @(negedge clk);
      if (kind == 1) check("perm_err_beat", 32'(perm_err), 32'(a >= 10));
      if (a == 62) check("tbl_ok_pre", 32'(tbl_ok), 32'd0);
      if (a == 63) begin
        check("tbl_ok_end", 32'(tbl_ok), 32'(kind != 1));
        check("perm_err_end", 32'(perm_err), 32'(kind == 1));
      end
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] va;
    int            nb;
    int            k;

    vt[0].din  = {6'h3f, 6'h3e, 6'h01, 6'h00};
    vt[0].dout = {6'h26, 6'h01, 6'h30, 6'h0b};
    vt[1].din  = {6'h2a, 6'h20, 6'h10, 6'h05};
    vt[1].dout = {6'h1d, 6'h2b, 6'h1b, 6'h04};
    vt[2].din  = {6'h2a, 6'h00, 6'h3f, 6'h17};
    vt[2].dout = {6'h1d, 6'h0b, 6'h26, 6'h1e};
    vt[3].din  = {6'h3f, 6'h3f, 6'h3f, 6'h3f};
    vt[3].dout = {6'h26, 6'h26, 6'h26, 6'h26};

    rst_n     = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cur_exp   = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_tbl_ok", 32'(tbl_ok), 32'd0);
    check("rst_perm_err", 32'(perm_err), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: load P.
    start_load();
    feed(0, 64);

    // 2: table vectors, then 100 back-to-back beats.
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vt[i].din;
      cur_exp  = vt[i].dout;
      @(negedge clk);
    end
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      d = {W'(i), W'(i * 3), W'(63 - i), W'(i * 5 + 1)};
      in_valid = 1'b1;
      in_data  = d;
      cur_exp  = fwd(d);
      #2;
      if (in_ready) nb++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_accepts", 32'(nb), 32'd100);
    repeat (4) @(negedge clk);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

`ifdef ODO_SBOX_INV_EN
    // 6: inverse lookup of P[k] returns k.
    in_valid = 1'b1;
    in_inv   = 1'b1;
    in_data  = {6'h26, 6'h1d, 6'h1e, 6'h0b};
    cur_exp  = {6'h3f, 6'h2a, 6'h17, 6'h00};
    @(negedge clk);
    in_valid = 1'b0;
    in_inv   = 1'b0;
    repeat (4) @(negedge clk);
    check("inv_drained", 32'(exp_q.size()), 32'd0);
`endif
    lat_chk = 1'b0;

    // 3: stall with 2 beats in flight and a third waiting.
    out_ready = 1'b0;
    va = {6'h01, 6'h02, 6'h03, 6'h04};
    in_valid = 1'b1;
    in_data  = va;
    cur_exp  = fwd(va);
    @(negedge clk);
    in_data  = {6'h11, 6'h12, 6'h13, 6'h14};
    cur_exp  = fwd(in_data);
    @(negedge clk);
    in_data  = {6'h21, 6'h22, 6'h23, 6'h24};
    cur_exp  = fwd(in_data);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall_out_data", 32'(out_data), 32'(fwd(va)));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // 5: ld_start with 2 beats in flight; the same-cycle beat is refused.
    in_valid = 1'b1;
    in_data  = {6'h30, 6'h31, 6'h32, 6'h33};
    cur_exp  = fwd(in_data);
    @(negedge clk);
    in_data  = {6'h0a, 6'h0b, 6'h0c, 6'h0d};
    cur_exp  = fwd(in_data);
    @(negedge clk);
    ld_start  = 1'b1;
    out_ready = 1'b0;
    in_data   = {6'h3c, 6'h3c, 6'h3c, 6'h3c};
    cur_exp   = fwd(in_data);
    #2;
    check("ldstart_blocks_in", 32'(in_ready), 32'd0);
    @(negedge clk);
    ld_start = 1'b0;
    in_valid = 1'b0;
    check("tbl_ok_after_start", 32'(tbl_ok), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("drain_ld_ready", 32'(ld_ready), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    k = 0;
    while (!ld_ready && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("reload_ld_ready", 32'(ld_ready), 32'd1);
    check("reload_out_valid", 32'(out_valid), 32'd0);
    check("reload_old_beats", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    feed(2, 30);
    ld_valid = 1'b1;
    ld_data  = val(2, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("async_rst_tbl_ok", 32'(tbl_ok), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    stamp_q.delete();
    @(negedge clk);
    ld_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // 4: load with a duplicate entry at addr 10.
    start_load();
    feed(1, 64);
    check("bad_ld_ready", 32'(ld_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = '0;
    #2;
    check("bad_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("bad_perm_err_sticky", 32'(perm_err), 32'd1);
    check("bad_tbl_ok", 32'(tbl_ok), 32'd0);
    check("bad_no_output", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
